// File: rtl/cmd_frame_parser.sv
// Command frame parser: splits a host word stream into a header handshake,
// a pass-through payload stream and a per-frame completion report.
module cmd_frame_parser #(
  parameter int unsigned host_width     = 16,
  parameter int unsigned num_slots      = 4,
  parameter int unsigned timeout_cycles = 1024
) (
  input  logic                  clk_host,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [host_width-1:0] in_data,
  output logic                  hdr_valid,
  input  logic                  hdr_ready,
  output logic [num_slots-1:0]  hdr_dest_mask,
  output logic [7:0]            hdr_command,
  output logic [23:0]           hdr_length,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic [host_width-1:0] data_out,
  output logic                  data_last,
  output logic                  done_valid,
  output logic                  done_csum_err,
  output logic                  done_timeout,
  output logic                  done_bad_dest,
  output logic [15:0]           frame_count,
  output logic [15:0]           error_count
);

  localparam int unsigned TMO_W = $clog2(timeout_cycles + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CMD     = 3'd1;
  localparam logic [2:0] LEN_HI  = 3'd2;
  localparam logic [2:0] LEN_LO  = 3'd3;
  localparam logic [2:0] HDR     = 3'd4;
  localparam logic [2:0] DATA    = 3'd5;
  localparam logic [2:0] CSUM_HI = 3'd6;
  localparam logic [2:0] CSUM_LO = 3'd7;

  logic [2:0]           state_q, state_d;
  logic [num_slots-1:0] mask_q, mask_d;
  logic                 bad_q, bad_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [23:0]          len_q, len_d;
  logic [23:0]          rem_q, rem_d;
  logic [31:0]          csum_q, csum_d;
  logic [15:0]          csum_hi_q, csum_hi_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 done_valid_q, done_valid_d;
  logic                 done_csum_err_q, done_csum_err_d;
  logic                 done_timeout_q, done_timeout_d;
  logic                 done_bad_dest_q, done_bad_dest_d;
  logic [15:0]          frame_count_q, frame_count_d;
  logic [15:0]          error_count_q, error_count_d;
  logic                 accept;

  // A discarded (bad-dest) payload is drained at full rate regardless of data_ready.
  always_comb begin
    in_ready = 1'b1;
    if (state_q == HDR) in_ready = 1'b0;
    else if (state_q == DATA && !bad_q) in_ready = data_ready;
  end

  assign accept        = in_valid && in_ready;
  assign hdr_valid     = (state_q == HDR);
  assign hdr_dest_mask = mask_q;
  assign hdr_command   = cmd_q;
  assign hdr_length    = len_q;
  assign data_valid    = (state_q == DATA) && !bad_q && in_valid;
  assign data_out      = in_data;
  assign data_last     = (state_q == DATA) && !bad_q && (rem_q == 24'd1);
  assign done_valid    = done_valid_q;
  assign done_csum_err = done_csum_err_q;
  assign done_timeout  = done_timeout_q;
  assign done_bad_dest = done_bad_dest_q;
  assign frame_count   = frame_count_q;
  assign error_count   = error_count_q;

  always_comb begin
    state_d         = state_q;
    mask_d          = mask_q;
    bad_d           = bad_q;
    cmd_d           = cmd_q;
    len_d           = len_q;
    rem_d           = rem_q;
    csum_d          = csum_q;
    csum_hi_d       = csum_hi_q;
    tmo_d           = tmo_q;
    done_valid_d    = 1'b0;
    done_csum_err_d = 1'b0;
    done_timeout_d  = 1'b0;
    done_bad_dest_d = 1'b0;
    frame_count_d   = frame_count_q;
    error_count_d   = error_count_q;

    case (state_q)
      IDLE: begin
        csum_d = '0;
        tmo_d  = '0;
        if (accept) begin
          mask_d = '0;
          bad_d  = 1'b0;
          if (in_data[7:0] == 8'hFF) mask_d = '1;
          else if (32'(in_data[7:0]) < num_slots) mask_d = num_slots'(1) << in_data[7:0];
          else bad_d = 1'b1;
          state_d = CMD;
        end
      end
      CMD: if (accept) begin
        cmd_d   = in_data[7:0];
        state_d = LEN_HI;
      end
      LEN_HI: if (accept) begin
        len_d[23:16] = in_data[7:0];
        state_d      = LEN_LO;
      end
      LEN_LO: if (accept) begin
        len_d[15:0] = in_data[15:0];
        rem_d       = {len_q[23:16], in_data[15:0]};
        if (!bad_q) state_d = HDR;
        else if ({len_q[23:16], in_data[15:0]} == 24'd0) state_d = CSUM_HI;
        else state_d = DATA;
      end
      HDR: if (hdr_ready) state_d = (len_q == 24'd0) ? CSUM_HI : DATA;
      DATA: if (accept) begin
        csum_d = csum_q + 32'(in_data[15:0]);
        rem_d  = rem_q - 24'd1;
        if (rem_q == 24'd1) state_d = CSUM_HI;
      end
      CSUM_HI: if (accept) begin
        csum_hi_d = in_data[15:0];
        state_d   = CSUM_LO;
      end
      default: if (accept) begin
        done_valid_d    = 1'b1;
        done_csum_err_d = ({csum_hi_q, in_data[15:0]} != csum_q);
        done_bad_dest_d = bad_q;
        state_d         = IDLE;
      end
    endcase

    // Input-starvation watchdog; overrides the word FSM when it fires.
    if (accept) tmo_d = '0;
    else if (in_ready && !in_valid && state_q != IDLE) begin
      if (32'(tmo_q) + 32'd1 >= timeout_cycles) begin
        tmo_d           = '0;
        state_d         = IDLE;
        done_valid_d    = 1'b1;
        done_timeout_d  = 1'b1;
        done_csum_err_d = 1'b0;
        done_bad_dest_d = 1'b0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    if (done_valid_d) begin
      if (frame_count_q != 16'hFFFF) frame_count_d = frame_count_q + 16'd1;
      if ((done_csum_err_d || done_timeout_d || done_bad_dest_d) && error_count_q != 16'hFFFF)
        error_count_d = error_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_host) begin
    if (reset) begin
      state_q         <= IDLE;
      mask_q          <= '0;
      bad_q           <= 1'b0;
      cmd_q           <= '0;
      len_q           <= '0;
      rem_q           <= '0;
      csum_q          <= '0;
      csum_hi_q       <= '0;
      tmo_q           <= '0;
      done_valid_q    <= 1'b0;
      done_csum_err_q <= 1'b0;
      done_timeout_q  <= 1'b0;
      done_bad_dest_q <= 1'b0;
      frame_count_q   <= '0;
      error_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      mask_q          <= mask_d;
      bad_q           <= bad_d;
      cmd_q           <= cmd_d;
      len_q           <= len_d;
      rem_q           <= rem_d;
      csum_q          <= csum_d;
      csum_hi_q       <= csum_hi_d;
      tmo_q           <= tmo_d;
      done_valid_q    <= done_valid_d;
      done_csum_err_q <= done_csum_err_d;
      done_timeout_q  <= done_timeout_d;
      done_bad_dest_q <= done_bad_dest_d;
      frame_count_q   <= frame_count_d;
      error_count_q   <= error_count_d;
    end
  end

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Self-checking bench for cmd_frame_parser: directed frames, a vector table,
// randomized frames against a frame-level reference model, timeout and reset cases.
module tb_cmd_frame_parser;

  localparam int unsigned HW = 16;
  localparam int unsigned NS = 4;
  localparam int unsigned TO = 1024;

  logic          clk_host = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [HW-1:0] in_data = '0;
  logic          hdr_valid;
  logic          hdr_ready = 1'b1;
  logic [NS-1:0] hdr_dest_mask;
  logic [7:0]    hdr_command;
  logic [23:0]   hdr_length;
  logic          data_valid;
  logic          data_ready = 1'b1;
  logic [HW-1:0] data_out;
  logic          data_last;
  logic          done_valid;
  logic          done_csum_err;
  logic          done_timeout;
  logic          done_bad_dest;
  logic [15:0]   frame_count;
  logic [15:0]   error_count;

  cmd_frame_parser #(
    .host_width(HW),
    .num_slots(NS),
    .timeout_cycles(TO)
  ) dut (
    .clk_host(clk_host), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_dest_mask(hdr_dest_mask),
    .hdr_command(hdr_command), .hdr_length(hdr_length),
    .data_valid(data_valid), .data_ready(data_ready), .data_out(data_out), .data_last(data_last),
    .done_valid(done_valid), .done_csum_err(done_csum_err), .done_timeout(done_timeout),
    .done_bad_dest(done_bad_dest), .frame_count(frame_count), .error_count(error_count)
  );

  always #5 clk_host = ~clk_host;

  typedef logic [15:0] wq_t [$];
  typedef struct { logic [NS-1:0] mask; logic [7:0] cmd; logic [23:0] len; } hdr_t;
  typedef struct { logic [15:0] data; logic last; } beat_t;
  typedef struct {
    logic [7:0] dest; logic [7:0] cmd; int len; logic [15:0] base; logic [31:0] adj;
    bit hdr; logic [NS-1:0] mask; bit bad; bit cerr;
  } vec_t;

  hdr_t        got_hdr[$];
  beat_t       got_beat[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          mode = 0;
  int          done_seen = 0;
  int          exp_done = 0;
  logic [15:0] exp_frames = '0;
  logic [15:0] exp_errs = '0;
  vec_t        vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Done flags must read zero whenever no done pulse is present.
  always @(negedge clk_host) begin
    if (done_valid) done_seen++;
    else begin
      n_cmp++;
      if (done_csum_err || done_timeout || done_bad_dest) begin
        n_fail++;
        $display("FAIL done_flags_idle: got %b%b%b, required 000", done_csum_err, done_timeout, done_bad_dest);
      end
    end
  end

  function automatic logic [31:0] sum_of(input wq_t p);
    logic [31:0] s = '0;
    foreach (p[i]) s += 32'(p[i]);
    return s;
  endfunction

  task automatic step_obs();
    hdr_t  h;
    beat_t b;
    if (hdr_valid && hdr_ready) begin
      h.mask = hdr_dest_mask; h.cmd = hdr_command; h.len = hdr_length;
      got_hdr.push_back(h);
    end
    if (data_valid) begin
      chk("in_ready_follows_data_ready", 32'(in_ready), 32'(data_ready));
      if (data_ready) begin
        b.data = data_out; b.last = data_last;
        got_beat.push_back(b);
      end
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    bit ok = 1'b0;
    for (int t = 0; t < 400 && !ok; t++) begin
      case (mode)
        0: begin in_valid = 1'b1; hdr_ready = 1'b1; data_ready = 1'b1; end
        1: begin in_valid = 1'b1; hdr_ready = 1'b1; data_ready = 1'($urandom_range(0, 1)); end
        default: begin
          in_valid   = ($urandom_range(0, 3) != 0);
          hdr_ready  = 1'($urandom_range(0, 1));
          data_ready = 1'($urandom_range(0, 1));
        end
      endcase
      in_data = w;
      #1;
      step_obs();
      ok = in_valid && in_ready;
      @(negedge clk_host);
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL send_word_stalled: word 0x%h not accepted within 400 cycles", w);
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] dest, input logic [7:0] cmd,
                           input logic [23:0] len, input wq_t pay, input logic [31:0] csum,
                           input bit e_hdr, input logic [NS-1:0] e_mask, input bit e_bad, input bit e_cerr);
    int e_beats;
    got_hdr.delete();
    got_beat.delete();
    send_word({8'h00, dest});
    send_word({8'h00, cmd});
    send_word({8'h00, len[23:16]});
    send_word(len[15:0]);
    foreach (pay[i]) send_word(pay[i]);
    send_word(csum[31:16]);
    send_word(csum[15:0]);
    chk({tag, "_done_valid"}, 32'(done_valid), 32'd1);
    chk({tag, "_csum_err"}, 32'(done_csum_err), 32'(e_cerr));
    chk({tag, "_bad_dest"}, 32'(done_bad_dest), 32'(e_bad));
    chk({tag, "_timeout"}, 32'(done_timeout), 32'd0);
    e_beats = e_hdr ? int'(len) : 0;
    chk({tag, "_hdr_count"}, 32'(got_hdr.size()), 32'(e_hdr));
    if (e_hdr && got_hdr.size() == 1) begin
      chk({tag, "_hdr_mask"}, 32'(got_hdr[0].mask), 32'(e_mask));
      chk({tag, "_hdr_cmd"}, 32'(got_hdr[0].cmd), 32'(cmd));
      chk({tag, "_hdr_len"}, 32'(got_hdr[0].len), 32'(len));
    end
    chk({tag, "_beat_count"}, 32'(got_beat.size()), 32'(e_beats));
    for (int i = 0; i < got_beat.size() && i < e_beats; i++) begin
      chk($sformatf("%s_beat%0d_data", tag, i), 32'(got_beat[i].data), 32'(pay[i]));
      chk($sformatf("%s_beat%0d_last", tag, i), 32'(got_beat[i].last), 32'(i == e_beats - 1));
    end
    exp_done++;
    if (exp_frames != 16'hFFFF) exp_frames++;
    if ((e_bad || e_cerr) && exp_errs != 16'hFFFF) exp_errs++;
    chk({tag, "_frame_count"}, 32'(frame_count), 32'(exp_frames));
    chk({tag, "_error_count"}, 32'(error_count), 32'(exp_errs));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    wq_t p;
    int  n;
    bit  found;

    vecs[0] = '{8'h00, 8'h11, 3, 16'h1234, 32'd0, 1'b1, 4'b0001, 1'b0, 1'b0};
    vecs[1] = '{8'h02, 8'h22, 1, 16'hFFFF, 32'd0, 1'b1, 4'b0100, 1'b0, 1'b0};
    vecs[2] = '{8'h03, 8'h33, 5, 16'h8000, 32'd1, 1'b1, 4'b1000, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 8'h44, 2, 16'h0000, 32'd0, 1'b1, 4'b1111, 1'b0, 1'b0};
    vecs[4] = '{8'h04, 8'h55, 2, 16'h0010, 32'd0, 1'b0, 4'b0000, 1'b1, 1'b0};
    vecs[5] = '{8'h09, 8'h66, 3, 16'h0007, 32'd0, 1'b0, 4'b0000, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'h77, 0, 16'h0000, 32'd1, 1'b0, 4'b0000, 1'b1, 1'b1};
    vecs[7] = '{8'h01, 8'h88, 0, 16'h0000, 32'd0, 1'b1, 4'b0010, 1'b0, 1'b0};

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk_host);
    chk("rst_hdr_valid", 32'(hdr_valid), 32'd0);
    chk("rst_data_valid", 32'(data_valid), 32'd0);
    chk("rst_data_last", 32'(data_last), 32'd0);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_error_count", 32'(error_count), 32'd0);
    reset = 1'b0;
    @(negedge clk_host);
    chk("rst_in_ready_after", 32'(in_ready), 32'd1);

    mode = 0;
    p = {16'h0005, 16'h0001};
    run_frame("basic", 8'h01, 8'h20, 24'd2, p, 32'h0000_0006, 1'b1, 4'b0010, 1'b0, 1'b0);
    chk("basic_frame_count_is_1", 32'(frame_count), 32'd1);

    p.delete();
    run_frame("bcast_len0", 8'hFF, 8'h30, 24'd0, p, 32'h0000_0000, 1'b1, 4'b1111, 1'b0, 1'b0);

    p = {16'h0005, 16'h0001};
    run_frame("csum_bad", 8'h01, 8'h20, 24'd2, p, 32'h0000_0007, 1'b1, 4'b0010, 1'b0, 1'b1);
    chk("csum_bad_error_count_is_1", 32'(error_count), 32'd1);

    p = {16'h0007};
    run_frame("bad_dest", 8'h09, 8'h10, 24'd1, p, 32'h0000_0007, 1'b0, 4'b0000, 1'b1, 1'b0);

    for (int k = 0; k < 8; k++) begin
      p.delete();
      for (int j = 0; j < vecs[k].len; j++) p.push_back(vecs[k].base + 16'(j) * 16'h0101);
      run_frame($sformatf("vec%0d", k), vecs[k].dest, vecs[k].cmd, 24'(vecs[k].len), p,
                sum_of(p) + vecs[k].adj, vecs[k].hdr, vecs[k].mask, vecs[k].bad, vecs[k].cerr);
    end

    // Long payload with data_ready toggling
    mode = 1;
    p.delete();
    for (int i = 0; i < 512; i++) p.push_back({8'(i / 256), 8'(i % 256)});
    run_frame("long512", 8'h00, 8'h5A, 24'd512, p, sum_of(p), 1'b1, 4'b0001, 1'b0, 1'b0);

    // Randomized frames against the frame-level model
    mode = 2;
    for (int f = 0; f < 40; f++) begin
      logic [7:0]    d;
      logic [23:0]   l;
      logic [31:0]   cs;
      logic [NS-1:0] m;
      bit            good;
      bit            cerr;
      case ($urandom_range(0, 5))
        0: d = 8'hFF;
        1: d = 8'($urandom_range(NS, 254));
        default: d = 8'($urandom_range(0, NS - 1));
      endcase
      l = 24'($urandom_range(0, 12));
      p.delete();
      for (int j = 0; j < int'(l); j++) p.push_back(16'($urandom));
      cs = sum_of(p);
      cerr = ($urandom_range(0, 3) == 0);
      if (cerr) cs = cs ^ (32'd1 << $urandom_range(0, 31));
      good = (d == 8'hFF) || (int'(d) < NS);
      m = (d == 8'hFF) ? '1 : (good ? NS'(1) << d : '0);
      run_frame($sformatf("rnd%0d", f), d, 8'($urandom), l, p, cs, good, m, !good, cerr);
    end

    // Input stops after len_lo: frame must time out
    mode = 0;
    send_word(16'h0001);
    send_word(16'h0040);
    send_word(16'h0000);
    send_word(16'h0004);
    in_valid = 1'b0;
    hdr_ready = 1'b1;
    data_ready = 1'b1;
    n = 0;
    found = 1'b0;
    while (!found && n < int'(TO) + 100) begin
      @(negedge clk_host);
      n++;
      if (done_valid) found = 1'b1;
    end
    chk("tmo_done_seen", 32'(found), 32'd1);
    chk("tmo_flag", 32'(done_timeout), 32'd1);
    chk("tmo_csum_err", 32'(done_csum_err), 32'd0);
    chk("tmo_bad_dest", 32'(done_bad_dest), 32'd0);
    chk("tmo_no_data_last", 32'(data_last), 32'd0);
    chk("tmo_latency_window", 32'(n >= int'(TO) && n <= int'(TO) + 8), 32'd1);
    exp_done++;
    exp_frames++;
    exp_errs++;
    chk("tmo_frame_count", 32'(frame_count), 32'(exp_frames));
    chk("tmo_error_count", 32'(error_count), 32'(exp_errs));
    @(negedge clk_host);
    chk("tmo_back_to_idle_ready", 32'(in_ready), 32'd1);
    p = {16'h0005, 16'h0001};
    run_frame("after_tmo", 8'h01, 8'h20, 24'd2, p, 32'h0000_0006, 1'b1, 4'b0010, 1'b0, 1'b0);

    // Reset in the middle of a payload
    send_word(16'h0002);
    send_word(16'h0021);
    send_word(16'h0000);
    send_word(16'h0004);
    send_word(16'h1111);
    send_word(16'h2222);
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 16'h3333;
    @(negedge clk_host);
    chk("midrst_hdr_valid", 32'(hdr_valid), 32'd0);
    chk("midrst_data_valid", 32'(data_valid), 32'd0);
    chk("midrst_data_last", 32'(data_last), 32'd0);
    chk("midrst_done_valid", 32'(done_valid), 32'd0);
    chk("midrst_frame_count", 32'(frame_count), 32'd0);
    chk("midrst_error_count", 32'(error_count), 32'd0);
    reset = 1'b0;
    in_valid = 1'b0;
    exp_frames = '0;
    exp_errs = '0;
    @(negedge clk_host);
    chk("midrst_in_ready_after", 32'(in_ready), 32'd1);
    chk("midrst_no_done", 32'(done_valid), 32'd0);
    p = {16'hA000, 16'h0B00, 16'h00C0, 16'h000D};
    run_frame("after_rst", 8'h02, 8'h21, 24'd4, p, 32'h0000_ABCD, 1'b1, 4'b0100, 1'b0, 1'b0);

    repeat (3) @(negedge clk_host);
    chk("done_pulse_total", 32'(done_seen), 32'(exp_done));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_frame_parser.md
CMD_FRAME_PARSER -- requirements
Module: cmd_frame_parser

Interface
REQ-001 SHALL have parameter host_width, default 16, meaning the word width of the host stream and data output (minimum 16).
REQ-002 SHALL have parameter num_slots, default 4, meaning the number of addressable slots (1..8).
REQ-003 SHALL have parameter timeout_cycles, default 1024, meaning the idle-input cycles mid-frame before the frame is aborted.
REQ-004 SHALL use one clock and a synchronous, active-high reset; ports: clk_host in 1, clock; reset in 1, synchronous active-high reset.
REQ-005 SHALL have ports: in_valid in 1; in_ready out 1; in_data in host_width, host word stream.
REQ-006 SHALL have ports: hdr_valid out 1; hdr_ready in 1; hdr_dest_mask out num_slots, one-hot or all-ones; hdr_command out 8; hdr_length out 24.
REQ-007 SHALL have ports: data_valid out 1; data_ready in 1; data_out out host_width; data_last out 1, marks the final payload word.
REQ-008 SHALL have ports: done_valid out 1, one-cycle pulse; done_csum_err out 1; done_timeout out 1; done_bad_dest out 1; frame_count out 16; error_count out 16.

Function
REQ-009 SHALL parse frames in this order: dest (in_data[7:0]), command ([7:0]), len_hi ([7:0] = length[23:16]), len_lo ([15:0] = length[15:0]), length payload words, csum_hi, csum_lo.
REQ-010 SHALL implement the states IDLE, CMD, LEN_HI, LEN_LO, HDR, DATA, CSUM_HI, CSUM_LO; each word state advances on an in_valid && in_ready cycle.
REQ-011 SHALL drive in_ready high in IDLE, CMD, LEN_HI, LEN_LO, CSUM_HI and CSUM_LO; low in HDR; equal to data_ready in DATA, or 1 in DATA when the frame is discarded.
REQ-012 SHALL decode dest < num_slots to a one-hot mask, and dest 0xFF to all-ones (broadcast).
REQ-013 SHALL treat any other dest as bad: no header and no data output, payload and checksum consumed, done_bad_dest set at frame end.
REQ-014 SHALL hold hdr_valid high in HDR with stable hdr_* fields until hdr_ready; on that handshake it SHALL go to DATA, or to CSUM_HI if length is 0.
REQ-015 SHALL pass data combinationally in DATA: data_valid = in_valid, data_out = in_data, data_last high when the remaining count equals 1.
REQ-016 SHALL count payload words down from length, 24-bit, with no wrap; length 0xFFFFFF is legal.
REQ-017 SHALL form the checksum as a 32-bit sum, modulo 2^32, of the zero-extended payload words [15:0], cleared at IDLE.
REQ-018 SHALL compare the sum against {csum_hi[15:0], csum_lo[15:0]} and set done_csum_err on mismatch.
REQ-019 SHALL pulse done_valid one cycle after the csum_lo accept, with flags valid in that cycle, then return to IDLE.
REQ-020 SHALL never stall the done pulse; there is no backpressure on done.
REQ-021 SHALL run a timeout counter that increments only when in_ready=1, in_valid=0 and the state is not IDLE, and clears on every accepted word.
REQ-022 SHALL abort when the timeout counter reaches timeout_cycles: pulse done_valid with done_timeout=1, drive no data_last, and return to IDLE.
REQ-023 SHALL increment frame_count on every done pulse, and error_count on every done pulse with any flag set; both SHALL saturate at 0xFFFF.
REQ-024 SHALL hold hdr_valid low outside HDR and data_valid low outside DATA, and SHALL drive the done flags to 0 when done_valid is 0.

Reset
REQ-025 SHALL on reset enter IDLE and clear the checksum, timeout counter, frame_count and error_count.
REQ-026 SHALL on reset drive hdr_valid=0, data_valid=0, data_last=0, done_valid=0 and all done flags=0; in_ready SHALL be 1 in the cycle after reset deasserts.
REQ-027 SHALL abandon a partial frame when reset is asserted mid-frame, with no done pulse.

Verification
REQ-028 SHALL be verified with this scenario: frame 01,20,00,0002, payload 0x0005,0x0001, csum 0000,0006 -> header mask 0010, cmd 0x20, len 2; two data words with last on the second; done, no flags; frame_count=1.
REQ-029 SHALL be verified with this scenario: dest FF, cmd 0x30, len 0, csum 0000,0000 -> header mask 1111, no data beats, done clean.
REQ-030 SHALL be verified with this scenario: 512-word payload of i/256, i%256 with data_ready toggling 50% -> all 512 words delivered in order, in_ready follows data_ready, done clean.
REQ-031 SHALL be verified with this scenario: the same frame as REQ-028 with csum 0000,0007 -> data delivered, done_csum_err=1, error_count=1.
REQ-032 SHALL be verified with these scenarios: dest 0x09 with len 1 -> nothing output, done_bad_dest=1; stop input after len_lo for 1024 cycles -> done_timeout=1, parser accepts the next frame.
REQ-033 SHALL be verified with this scenario: reset asserted during DATA of a len 4 frame -> outputs cleared next cycle, no done pulse, next frame parsed correctly.
